// File: rtl/image_overlay_draw.sv
// Greyscale ROM image overlay with scaling, transparency key, channel mask
// and frame-timed fade FSM; delays sync/blank to stay aligned with rgb_out.
// Ports: system_clock_in/reset_n_in (sync, active-low); hcount/vcount,
//   hsync/vsync/blank, bg_rgb_in from the timing generator; x_in/y_in,
//   scale_log2_in, channel_mask_in, show_in/hide_in controls; rom_addr_out/
//   rom_data_in to the image ROM; rgb_out, hsync_out, vsync_out, blank_out,
//   visible_out, fade_busy_out to the display mux.
module image_overlay_draw #(
   parameter int         WIDTH           = 80,
   parameter int         HEIGHT          = 256,
   parameter int         ADDR_W          = 15,
   parameter int         ROM_LATENCY     = 2,
   parameter int         FRAMES_PER_STEP = 4,
   parameter bit         TRANSPARENT_EN  = 1'b1,
   parameter logic [7:0] TRANSPARENT_KEY = 8'h00
) (
   input  logic              system_clock_in,
   input  logic              reset_n_in,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              blank,
   input  logic [11:0]       bg_rgb_in,
   input  logic [10:0]       x_in,
   input  logic [9:0]        y_in,
   input  logic [1:0]        scale_log2_in,
   input  logic [2:0]        channel_mask_in,
   input  logic              show_in,
   input  logic              hide_in,
   output logic [ADDR_W-1:0] rom_addr_out,
   input  logic [7:0]        rom_data_in,
   output logic [11:0]       rgb_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              blank_out,
   output logic              visible_out,
   output logic              fade_busy_out
);

   // Side-band delay so it lines up with rom_data_in at the output stage.
   localparam int DL = ROM_LATENCY + 1;
   localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {IDLE, FADE_IN, SHOWN, FADE_OUT} state_t;

   state_t            state_q, state_d;
   logic [3:0]        bright_q, bright_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              vis_q, busy_q;

   logic              vs_prev_q;
   logic [10:0]       xl_q;
   logic [9:0]        yl_q;
   logic [1:0]        sl_q;

   logic [ADDR_W-1:0] rom_addr_q, addr_d;
   logic [11:0]       bg_dl_q [DL];
   logic [DL-1:0]     hs_dl_q, vs_dl_q, bl_dl_q, rg_dl_q;

   logic [11:0]       rgb_q, rgb_d;
   logic              hs_q, vs_q, bl_q;

   logic              tick;
   logic [1:0]        scale_eff;
   logic [11:0]       hc, vc, xs, ys, xe, ye, dx, dy;
   logic              in_reg;
   logic [4:0]        bmul;
   logic [12:0]       prod;
   logic [3:0]        lvl;

   assign tick      = vs_prev_q & ~vsync;
   assign scale_eff = (scale_log2_in == 2'd3) ? 2'd2 : scale_log2_in;

   // Region test at 12 bits so xl+scaled width never wraps.
   always_comb begin
      hc     = {1'b0, hcount};
      vc     = {2'b0, vcount};
      xs     = {1'b0, xl_q};
      ys     = {2'b0, yl_q};
      xe     = xs + (12'(WIDTH) << sl_q);
      ye     = ys + (12'(HEIGHT) << sl_q);
      in_reg = (hc >= xs) && (hc < xe) && (vc >= ys) && (vc < ye);
      dx     = (hc - xs) >> sl_q;
      dy     = (vc - ys) >> sl_q;
      addr_d = ADDR_W'(dy) * ADDR_W'(WIDTH) + ADDR_W'(dx);
   end

   // Output stage: scale grey by brightness, then pick blank/bg/image.
   always_comb begin
      bmul = {1'b0, bright_q} + 5'd1;
      prod = {5'b0, rom_data_in} * {8'b0, bmul};
      lvl  = prod[11:8];
      if (bl_dl_q[DL-1]) begin
         rgb_d = '0;
      end else if ((state_q == IDLE) || !rg_dl_q[DL-1] ||
                   (TRANSPARENT_EN && (rom_data_in == TRANSPARENT_KEY))) begin
         rgb_d = bg_dl_q[DL-1];
      end else begin
         rgb_d = {channel_mask_in[2] ? lvl : 4'h0,
                  channel_mask_in[1] ? lvl : 4'h0,
                  channel_mask_in[0] ? lvl : 4'h0};
      end
   end

   // Pulses are applied first; a coincident tick then counts in the new state.
   always_comb begin
      state_d  = state_q;
      bright_d = bright_q;
      cnt_d    = cnt_q;
      if (hide_in) begin
         if (state_q == FADE_IN || state_q == SHOWN) begin
            state_d = FADE_OUT;
            cnt_d   = '0;
         end
      end else if (show_in) begin
         if (state_q == IDLE) begin
            state_d  = FADE_IN;
            bright_d = '0;
            cnt_d    = '0;
         end else if (state_q == FADE_OUT) begin
            state_d = FADE_IN;
            cnt_d   = '0;
         end
      end
      if (tick) begin
         unique case (state_d)
            FADE_IN: begin
               if (bright_d == 4'hF) begin
                  state_d = SHOWN;
               end else if (cnt_d == CNT_LAST) begin
                  cnt_d    = '0;
                  bright_d = bright_d + 4'd1;
                  if (bright_d == 4'hF) state_d = SHOWN;
               end else begin
                  cnt_d = cnt_d + CW'(1);
               end
            end
            FADE_OUT: begin
               if (bright_d == 4'h0) begin
                  state_d = IDLE;
               end else if (cnt_d == CNT_LAST) begin
                  cnt_d    = '0;
                  bright_d = bright_d - 4'd1;
                  if (bright_d == 4'h0) state_d = IDLE;
               end else begin
                  cnt_d = cnt_d + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge system_clock_in) begin
      if (!reset_n_in) begin
         state_q  <= IDLE;
         bright_q <= '0;
         cnt_q    <= '0;
         vis_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bright_q <= bright_d;
         cnt_q    <= cnt_d;
         vis_q    <= (state_d != IDLE);
         busy_q   <= (state_d == FADE_IN) || (state_d == FADE_OUT);
      end
   end

   always_ff @(posedge system_clock_in) begin
      if (!reset_n_in) begin
         vs_prev_q  <= 1'b1;
         xl_q       <= '0;
         yl_q       <= '0;
         sl_q       <= '0;
         rom_addr_q <= '0;
         for (int i = 0; i < DL; i++) bg_dl_q[i] <= '0;
         hs_dl_q    <= '1;
         vs_dl_q    <= '1;
         bl_dl_q    <= '1;
         rg_dl_q    <= '0;
         rgb_q      <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         bl_q       <= 1'b1;
      end else begin
         vs_prev_q <= vsync;
         if (tick) begin
            xl_q <= x_in;
            yl_q <= y_in;
            sl_q <= scale_eff;
         end
         rom_addr_q <= addr_d;
         for (int i = DL - 1; i > 0; i--) bg_dl_q[i] <= bg_dl_q[i-1];
         bg_dl_q[0] <= bg_rgb_in;
         hs_dl_q    <= {hs_dl_q[DL-2:0], hsync};
         vs_dl_q    <= {vs_dl_q[DL-2:0], vsync};
         bl_dl_q    <= {bl_dl_q[DL-2:0], blank};
         rg_dl_q    <= {rg_dl_q[DL-2:0], in_reg};
         rgb_q      <= rgb_d;
         hs_q       <= hs_dl_q[DL-1];
         vs_q       <= vs_dl_q[DL-1];
         bl_q       <= bl_dl_q[DL-1];
      end
   end

   assign rom_addr_out  = rom_addr_q;
   assign rgb_out       = rgb_q;
   assign hsync_out     = hs_q;
   assign vsync_out     = vs_q;
   assign blank_out     = bl_q;
   assign visible_out   = vis_q;
   assign fade_busy_out = busy_q;

endmodule

// File: tb/tb_image_overlay_draw.sv
// Directed bench for image_overlay_draw: reset, fades, scaling, mask,
// transparency, region bounds, frame-latched position and sync alignment.
module tb_image_overlay_draw;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, blank;
   logic [11:0] bg;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic [1:0]  scale;
   logic [2:0]  mask;
   logic        show, hide;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;
   logic [11:0] rgb;
   logic        hs_o, vs_o, bl_o, vis, busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   image_overlay_draw dut (
      .system_clock_in (clk),
      .reset_n_in      (reset_n),
      .hcount          (hcount),
      .vcount          (vcount),
      .hsync           (hsync),
      .vsync           (vsync),
      .blank           (blank),
      .bg_rgb_in       (bg),
      .x_in            (x_in),
      .y_in            (y_in),
      .scale_log2_in   (scale),
      .channel_mask_in (mask),
      .show_in         (show),
      .hide_in         (hide),
      .rom_addr_out    (rom_addr),
      .rom_data_in     (rom_data),
      .rgb_out         (rgb),
      .hsync_out       (hs_o),
      .vsync_out       (vs_o),
      .blank_out       (bl_o),
      .visible_out     (vis),
      .fade_busy_out   (busy)
   );

   // ROM model: two-cycle latency, grey = low address byte.
   logic [14:0] rp1, rp2;
   always @(posedge clk) begin
      rp1 <= rom_addr;
      rp2 <= rp1;
   end
   assign rom_data = rp2[7:0];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_tick();
      vsync = 1'b0;
      step(1);
      vsync = 1'b1;
      step(1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) frame_tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; vsync = 1'b1; hsync = 1'b1; blank = 1'b0;
      bg = 12'h123; hcount = '0; vcount = '0; x_in = '0; y_in = '0;
      scale = '0; mask = 3'b111; show = 1'b0; hide = 1'b0;
      step(3);
      checks++; if (rgb !== 12'h000) begin failures++;
         $display("FAIL rst_rgb got=%h exp=000", rgb); end
      checks++; if ({hs_o, vs_o, bl_o} !== 3'b111) begin failures++;
         $display("FAIL rst_sync got=%b exp=111", {hs_o, vs_o, bl_o}); end
      checks++; if ({vis, busy} !== 2'b00) begin failures++;
         $display("FAIL rst_flags got=%b exp=00", {vis, busy}); end
      checks++; if (rom_addr !== 15'd0) begin failures++;
         $display("FAIL rst_addr got=%0d exp=0", rom_addr); end
      reset_n = 1'b1;
      step(3);
      checks++; if (rgb !== 12'h000 || bl_o !== 1'b1) begin failures++;
         $display("FAIL rel_lat3 rgb=%h blank=%b exp=000/1", rgb, bl_o); end
      step(1);
      checks++; if (rgb !== 12'h123 || bl_o !== 1'b0) begin failures++;
         $display("FAIL rel_bg rgb=%h blank=%b exp=123/0", rgb, bl_o); end
   endtask

   task automatic test_fade_in();
      x_in = 11'd0; y_in = 10'd0; scale = 2'd0;
      frame_tick();
      hcount = 11'd15; vcount = 10'd3;
      show = 1'b1; step(1); show = 1'b0;
      checks++; if ({vis, busy} !== 2'b11) begin failures++;
         $display("FAIL show_flags got=%b exp=11", {vis, busy}); end
      ticks(3); step(4);
      checks++; if (rgb !== 12'h000) begin failures++;
         $display("FAIL fade_b0 got=%h exp=000", rgb); end
      frame_tick(); step(4);
      checks++; if (rgb !== 12'h111) begin failures++;
         $display("FAIL fade_b1 got=%h exp=111", rgb); end
      ticks(55);
      checks++; if (busy !== 1'b1) begin failures++;
         $display("FAIL busy59 got=%b exp=1", busy); end
      vsync = 1'b0; step(1);
      checks++; if ({vis, busy} !== 2'b10) begin failures++;
         $display("FAIL shown_flags got=%b exp=10", {vis, busy}); end
      vsync = 1'b1; step(5);
      checks++; if (rgb !== 12'hFFF) begin failures++;
         $display("FAIL fade_b15 got=%h exp=FFF", rgb); end
   endtask

   task automatic test_scale_mask();
      x_in = 11'd100; y_in = 10'd50; scale = 2'd1;
      frame_tick();
      hcount = 11'd103; vcount = 10'd55;
      step(1);
      checks++; if (rom_addr !== 15'd161) begin failures++;
         $display("FAIL addr got=%0d exp=161", rom_addr); end
      step(3);
      checks++; if (rgb !== 12'hAAA) begin failures++;
         $display("FAIL pix_111 got=%h exp=AAA", rgb); end
      mask = 3'b100; step(1);
      checks++; if (rgb !== 12'hA00) begin failures++;
         $display("FAIL pix_100 got=%h exp=A00", rgb); end
      mask = 3'b111; step(1);
   endtask

   task automatic test_transparent_bounds();
      bg = 12'h5C3;
      hcount = 11'd100; vcount = 10'd50; step(4);
      checks++; if (rgb !== 12'h5C3) begin failures++;
         $display("FAIL transp got=%h exp=5C3", rgb); end
      hcount = 11'd259; vcount = 10'd55; step(4);
      checks++; if (rgb !== 12'hEEE) begin failures++;
         $display("FAIL x_last got=%h exp=EEE", rgb); end
      hcount = 11'd260; step(4);
      checks++; if (rgb !== 12'h5C3) begin failures++;
         $display("FAIL x_past got=%h exp=5C3", rgb); end
      hcount = 11'd99; step(4);
      checks++; if (rgb !== 12'h5C3) begin failures++;
         $display("FAIL x_before got=%h exp=5C3", rgb); end
      hcount = 11'd103; vcount = 10'd561; step(4);
      checks++; if (rgb !== 12'hBBB) begin failures++;
         $display("FAIL y_last got=%h exp=BBB", rgb); end
      vcount = 10'd562; step(4);
      checks++; if (rgb !== 12'h5C3) begin failures++;
         $display("FAIL y_past got=%h exp=5C3", rgb); end
   endtask

   task automatic test_fade_out();
      hcount = 11'd130; vcount = 10'd56; step(4);
      checks++; if (rgb !== 12'hFFF) begin failures++;
         $display("FAIL g255_b15 got=%h exp=FFF", rgb); end
      hide = 1'b1; step(1); hide = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++;
         $display("FAIL hide_busy got=%b exp=1", busy); end
      ticks(4); step(4);
      checks++; if (rgb !== 12'hEEE) begin failures++;
         $display("FAIL out_b14 got=%h exp=EEE", rgb); end
      ticks(55);
      checks++; if (vis !== 1'b1) begin failures++;
         $display("FAIL out59_vis got=%b exp=1", vis); end
      frame_tick();
      checks++; if ({vis, busy} !== 2'b00) begin failures++;
         $display("FAIL out_idle got=%b exp=00", {vis, busy}); end
      step(4);
      checks++; if (rgb !== 12'h5C3) begin failures++;
         $display("FAIL idle_bg got=%h exp=5C3", rgb); end
   endtask

   task automatic test_hide_show_same();
      show = 1'b1; step(1); show = 1'b0;
      ticks(28); step(4);
      checks++; if (rgb !== 12'h777) begin failures++;
         $display("FAIL in_b7 got=%h exp=777", rgb); end
      hide = 1'b1; show = 1'b1; step(1); hide = 1'b0; show = 1'b0;
      ticks(27); step(4);
      checks++; if (rgb !== 12'h111 || vis !== 1'b1) begin failures++;
         $display("FAIL both_b1 rgb=%h vis=%b exp=111/1", rgb, vis); end
      frame_tick();
      checks++; if (vis !== 1'b0) begin failures++;
         $display("FAIL both_idle got=%b exp=0", vis); end
      step(4);
      checks++; if (rgb !== 12'h5C3) begin failures++;
         $display("FAIL both_bg got=%h exp=5C3", rgb); end
   endtask

   task automatic test_move_midframe();
      show = 1'b1; step(1); show = 1'b0;
      ticks(60);
      checks++; if ({vis, busy} !== 2'b10) begin failures++;
         $display("FAIL reshown got=%b exp=10", {vis, busy}); end
      hcount = 11'd103; vcount = 10'd55; step(4);
      checks++; if (rgb !== 12'hAAA) begin failures++;
         $display("FAIL pre_move got=%h exp=AAA", rgb); end
      x_in = 11'd50; step(6);
      checks++; if (rgb !== 12'hAAA) begin failures++;
         $display("FAIL mid_move got=%h exp=AAA", rgb); end
      frame_tick(); step(4);
      checks++; if (rgb !== 12'hBBB) begin failures++;
         $display("FAIL post_move got=%h exp=BBB", rgb); end
      blank = 1'b1; hsync = 1'b0; step(1); blank = 1'b0; hsync = 1'b1;
      step(2);
      checks++; if (rgb !== 12'hBBB || bl_o !== 1'b0) begin failures++;
         $display("FAIL blank_early rgb=%h bl=%b exp=BBB/0", rgb, bl_o); end
      step(1);
      checks++; if (rgb !== 12'h000 || bl_o !== 1'b1 || hs_o !== 1'b0) begin
         failures++;
         $display("FAIL blank_hit rgb=%h bl=%b hs=%b exp=000/1/0",
                  rgb, bl_o, hs_o); end
      step(1);
      checks++; if (rgb !== 12'hBBB || bl_o !== 1'b0 || hs_o !== 1'b1) begin
         failures++;
         $display("FAIL blank_after rgb=%h bl=%b hs=%b exp=BBB/0/1",
                  rgb, bl_o, hs_o); end
   endtask

   task automatic test_reset_midfade();
      hide = 1'b1; step(1); hide = 1'b0;
      ticks(5);
      reset_n = 1'b0; step(1);
      checks++; if ({vis, busy} !== 2'b00 || rgb !== 12'h000) begin
         failures++;
         $display("FAIL mid_rst flags=%b rgb=%h exp=00/000", {vis, busy}, rgb);
      end
      reset_n = 1'b1; step(4);
      checks++; if (rgb !== 12'h5C3 || vis !== 1'b0) begin failures++;
         $display("FAIL mid_rst_bg rgb=%h vis=%b exp=5C3/0", rgb, vis); end
   endtask

   initial begin
      test_reset();
      test_fade_in();
      test_scale_mask();
      test_transparent_bounds();
      test_fade_out();
      test_hide_show_same();
      test_move_midframe();
      test_reset_midfade();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/image_overlay_draw.md
Name: image_overlay_draw

Overview:
- Parametrised greyscale image-overlay renderer for the XVGA pixel pipeline.
- Places a ROM-stored WIDTH x HEIGHT image at a runtime position with 1x/2x/4x integer scaling, per-pixel transparency key and per-channel mask.
- Applies a frame-timed fade-in/fade-out brightness FSM; otherwise passes a background pixel through.
- Delays hsync/vsync/blank to stay aligned with rgb_out; sits between the VGA timing generator and the display output mux.

Parameters:
- WIDTH, 80, image width in pixels
- HEIGHT, 256, image height in pixels
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- ROM_LATENCY, 2, cycles from rom_addr_out to valid rom_data_in (1..4)
- FRAMES_PER_STEP, 4, frames per brightness step during fades (>=1)
- TRANSPARENT_EN, 1, enables the transparency key
- TRANSPARENT_KEY, 8'h00, grey value treated as transparent

Ports:
- system_clock_in  in  1  pixel clock
- reset_n_in  in  1  synchronous reset, active-low
- hcount  in  11  current pixel x
- vcount  in  10  current pixel y
- hsync  in  1  active-low hsync
- vsync  in  1  active-low vsync
- blank  in  1  1 = outside visible area
- bg_rgb_in  in  12  background pixel, aligned with hcount/vcount
- x_in  in  11  image left edge
- y_in  in  10  image top edge
- scale_log2_in  in  2  0=1x, 1=2x, 2=4x; 3 treated as 2
- channel_mask_in  in  3  {R,G,B} enables
- show_in  in  1  one-cycle pulse: start fade-in
- hide_in  in  1  one-cycle pulse: start fade-out
- rom_addr_out  out  ADDR_W  image ROM address
- rom_data_in  in  8  image ROM grey data
- rgb_out  out  12  {R,G,B} 4 bits each
- hsync_out, vsync_out, blank_out  out  1 each  delayed timing signals
- visible_out  out  1  state != IDLE
- fade_busy_out  out  1  state is FADE_IN or FADE_OUT

Behaviour:
- Reset (reset_n_in=0 at a clock edge): rgb_out=0, rom_addr_out=0, hsync_out=1, vsync_out=1, blank_out=1, visible_out=0, fade_busy_out=0, state=IDLE, brightness=0, frame counter=0, latched x/y/scale=0. All pipeline stages are cleared to the same values.
- Frame tick: vsync falls (previous 1, current 0). On each tick, x_in, y_in and scale_log2_in are latched as xl, yl, sl. The image does not move or rescale mid-frame.
- Region: hcount in [xl, xl+(WIDTH<<sl)) and vcount in [yl, yl+(HEIGHT<<sl)). Compare at 12-bit width so no wrap occurs.
- Address: ((vcount-yl)>>sl)*WIDTH + ((hcount-xl)>>sl), truncated to ADDR_W. Outside the region the address is don't-care.
- Pipeline timing for inputs sampled at cycle t:
  - rom_addr_out and the in_region flag are registered at t+1.
  - rom_data_in is used at t+1+ROM_LATENCY.
  - rgb_out, hsync_out, vsync_out, blank_out are registered at t+2+ROM_LATENCY (4 at default).
  - bg_rgb_in, in_region and sync/blank travel through matching delay lines.
- Pixel level: lvl = (grey*(brightness+1))>>8, 4 bits. brightness=15 gives grey[7:4]; brightness=0 gives 0.
- Output select, first match wins:
  1. blank delayed = 1 -> 0.
  2. state IDLE, or not in_region, or (TRANSPARENT_EN and grey==TRANSPARENT_KEY) -> bg delayed.
  3. Otherwise {mask[2]?lvl:0, mask[1]?lvl:0, mask[0]?lvl:0}.
- FSM (IDLE, FADE_IN, SHOWN, FADE_OUT); brightness changes only on frame ticks:
  - IDLE: show_in -> FADE_IN, brightness=0, counter=0.
  - FADE_IN: on each tick, counter++. At FRAMES_PER_STEP-1, counter resets to 0 and brightness++. When brightness reaches 15 -> SHOWN. hide_in -> FADE_OUT, keeping current brightness and counter=0.
  - SHOWN: hide_in -> FADE_OUT; show_in ignored.
  - FADE_OUT: mirror of FADE_IN, decrementing. At brightness 0 -> IDLE. show_in -> FADE_IN from current brightness.
  - show_in and hide_in in the same cycle: hide_in wins.
  - A pulse arriving in the same cycle as a tick is applied first; the tick then counts in the new state.
- Reset mid-fade: returns to IDLE, brightness 0. The output becomes pure background once the pipeline is cleared.

Test Plan:
- Reset held 3 cycles, then released with vsync=1 -> rgb_out=0, hsync_out=vsync_out=blank_out=1, visible_out=0. After release, bg_rgb_in=12'h123 in the visible area gives rgb_out=12'h123 four cycles later.
- show_in, FRAMES_PER_STEP=4 -> brightness 1 after 4 ticks, reaches 15 after 60 ticks. fade_busy_out drops in the cycle SHOWN is entered.
- SHOWN, x=100, y=50, scale=1 (2x); ROM model returns grey=addr[7:0]:
  - hcount=103, vcount=55 -> rom_addr_out=2*80+1=161.
  - rgb_out = 12'hAAA (grey=161, level 10) with mask 3'b111.
  - rgb_out = 12'hA00 with mask 3'b100.
- Pixel with grey=8'h00 and TRANSPARENT_EN=1 -> bg passthrough. A pixel at hcount=260 (just past 100+160) also gives bg.
- hide_in mid-FADE_IN at brightness 7, with show_in pulsed in the same cycle -> FADE_OUT. Brightness decrements from 7 and reaches IDLE after 28 ticks.
- Change x_in mid-frame -> no rgb_out change until after the next vsync falling edge. Blank asserted inside the image region -> rgb_out=0 with 4-cycle alignment.
